// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver running on the system clock.
//   The line is synchronized with two flops and sampled with a 3-tap majority
//   vote around each bit center. Each good byte lands in a one-entry output
//   register that is held until the consumer acknowledges it with rd_i.
// Ports:
//   clk_i       system clock
//   rstn_i      asynchronous active-low reset
//   line_i      serial input, idle high, asynchronous to clk_i
//   rd_i        consumer acknowledge, clears valid_o
//   data_o      last good byte received
//   valid_o     data_o holds an unread byte
//   frame_err_o one-cycle pulse when the stop bit is sampled low
//   overrun_o   one-cycle pulse when an unread byte is overwritten
//   busy_o      receiver is not idle
module uart_rx #(
  parameter int CLK_HZ       = 24000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       line_i,
  input  logic       rd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);
  localparam int MID = CLKS_PER_BIT / 2;

  // Start bit: vote at MID-1..MID+1 from the detected edge.
  localparam logic [CNT_W-1:0] ST_S0  = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] ST_S1  = CNT_W'(MID);
  localparam logic [CNT_W-1:0] ST_DEC = CNT_W'(MID + 1);
  // Data/stop bits: the counter restarts at the start-bit decision, so the
  // same window shifted by one full bit sits just before the wrap.
  localparam logic [CNT_W-1:0] BT_S0  = CNT_W'(CLKS_PER_BIT - 3);
  localparam logic [CNT_W-1:0] BT_S1  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] BT_DEC = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK_WAIT} state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       vote_q, vote_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic [CNT_W-1:0] s0_pt, s1_pt, dec_pt, cnt_nxt;
  logic             counting, at_dec, vote, commit;

  always_comb begin
    sync1_d     = line_i;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    vote_d      = vote_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    commit      = 1'b0;

    counting = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    s0_pt    = (state_q == START) ? ST_S0  : BT_S0;
    s1_pt    = (state_q == START) ? ST_S1  : BT_S1;
    dec_pt   = (state_q == START) ? ST_DEC : BT_DEC;
    at_dec   = counting && (cnt_q == dec_pt);
    cnt_nxt  = (cnt_q == BT_DEC) ? '0 : cnt_q + 1'b1;

    // First two taps are stored; the third is the live synchronized line.
    if (counting && cnt_q == s0_pt) vote_d[0] = sync2_q;
    if (counting && cnt_q == s1_pt) vote_d[1] = sync2_q;
    vote = (vote_q[0] & vote_q[1]) | (vote_q[0] & sync2_q) | (vote_q[1] & sync2_q);

    case (state_q)
      IDLE: begin
        if (prev_q && !sync2_q) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        cnt_d = cnt_nxt;
        if (at_dec) begin
          if (vote) begin
            state_d = IDLE;           // false start, dropped silently
          end else begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        cnt_d = cnt_nxt;
        if (at_dec) begin
          shift_d = {vote, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_nxt;
        if (at_dec) begin
          if (vote) begin
            commit  = 1'b1;
            state_d = IDLE;           // leave early so a short stop bit still works
          end else begin
            frame_err_d = 1'b1;
            state_d     = BRK_WAIT;   // one error per low period, however long
          end
        end
      end
      BRK_WAIT: begin
        if (sync2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A commit wins over an acknowledge in the same cycle.
    if (commit) begin
      data_d    = shift_q;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~rd_i;
    end else if (rd_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      vote_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      vote_q      <= vote_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: drives whole 8N1 frames on the line and keeps a
// frame-level model (one outcome per frame at a fixed latency from its start
// edge, plus the valid/read handshake) that is compared every cycle.
module tb_uart_rx;
  localparam int CPB = 24000000 / 115200;
  localparam int MID = CPB / 2;
  // start edge -> output: 2 sync cycles + 9.5 bit times + 2 cycles
  localparam int LAT = 2 + 9 * CPB + MID + 2;

  logic       clk_i = 1'b0, rstn_i = 1'b0, line_i = 1'b1, rd_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overrun_o, busy_o;

  uart_rx dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .line_i(line_i), .rd_i(rd_i),
    .data_o(data_o), .valid_o(valid_o), .frame_err_o(frame_err_o),
    .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {int at; bit fe; logic [7:0] b;} ev_t;
  ev_t ev_q[$];

  int   cyc = 0, checks = 0, errors = 0;
  int   fe_cnt = 0, ov_cnt = 0, vrise = 0;
  logic rd_s = 1'b0, valid_prev = 1'b0;
  logic m_valid = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit   rand_rd = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk_i) begin
    cyc++;
    rd_s = rd_i;
  end

  // Model update and compare, half a cycle after each active edge.
  always @(negedge clk_i) begin
    ev_t  e;
    logic commit;
    commit = 1'b0;
    m_fe   = 1'b0;
    m_ov   = 1'b0;
    if (!rstn_i) begin
      ev_q.delete();
      m_valid = 1'b0;
      m_data  = 8'h00;
    end else begin
      if (ev_q.size() != 0 && ev_q[0].at == cyc) begin
        e = ev_q.pop_front();
        if (e.fe) m_fe = 1'b1;
        else begin
          commit = 1'b1;
          if (m_valid && !rd_s) m_ov = 1'b1;
          m_data  = e.b;
          m_valid = 1'b1;
        end
      end
      if (!commit && rd_s) m_valid = 1'b0;
    end
    chk("valid_o", valid_o, m_valid);
    chk("data_o", data_o, m_data);
    chk("frame_err_o", frame_err_o, m_fe);
    chk("overrun_o", overrun_o, m_ov);
    if (frame_err_o) fe_cnt++;
    if (overrun_o) ov_cnt++;
    if (valid_o && !valid_prev) vrise++;
    valid_prev = valid_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    line_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      rd_i = rand_rd && ($urandom_range(0, 63) == 0);
      tick();
    end
    rd_i = 1'b0;
  endtask

  task automatic read_pulse();
    rd_i = 1'b1;
    tick();
    rd_i = 1'b0;
  endtask

  // One frame: start, 8 data bits LSB first, stop of stop_len cycles.
  // glitch_k: one-cycle low pulse at that cycle (-1 none).
  // rd_off:   pulse rd_i at commit + rd_off (-1: random/none).
  // rst_k:    hold reset low for 3 cycles from that cycle (-1 none).
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input int stop_len, input int glitch_k,
                            input int rd_off, input int rst_k);
    int   t;
    logic v;
    t = cyc + 1;
    ev_q.push_back('{at: t + LAT, fe: !stop_ok, b: b});
    for (int k = 0; k < 9 * CPB + stop_len; k++) begin
      int bi;
      bi = k / CPB;
      if (bi == 0)      v = 1'b0;
      else if (bi <= 8) v = b[bi-1];
      else              v = stop_ok;
      if (k == glitch_k) v = 1'b0;
      line_i = v;
      if (rd_off >= 0) rd_i = (cyc + 1 == t + LAT + rd_off);
      else             rd_i = rand_rd && ($urandom_range(0, 63) == 0);
      rstn_i = !(rst_k >= 0 && k >= rst_k && k < rst_k + 3);
      if (k == 4 * CPB) chk("busy_mid_frame", busy_o, 1);
      if (rst_k >= 0 && k == rst_k + 1) begin
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_busy", busy_o, 0);
      end
      tick();
    end
    line_i = 1'b1;
    rd_i   = 1'b0;
    rstn_i = 1'b1;
  endtask

  initial begin
    int v0, f0, o0;
    logic [7:0] rb;
    bit ok;
    int sl, gk;

    // reset state
    repeat (5) tick();
    chk("reset_data", data_o, 8'h00);
    chk("reset_valid", valid_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_ferr", frame_err_o, 0);
    rstn_i = 1'b1;
    idle(20);

    // 1: single 0x55
    v0 = vrise; f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'h55, 1, CPB, -1, -1, -1);
    idle(20);
    chk("t1_data", data_o, 8'h55);
    chk("t1_valid", valid_o, 1);
    chk("t1_vrise", vrise - v0, 1);
    chk("t1_errs", (fe_cnt - f0) + (ov_cnt - o0), 0);
    chk("t1_idle_busy", busy_o, 0);
    read_pulse();

    // 2: back-to-back 0x48, 0x69 with reads after each
    v0 = vrise; o0 = ov_cnt;
    send_frame(8'h48, 1, CPB, -1, 10, -1);
    send_frame(8'h69, 1, CPB, -1, 10, -1);
    idle(20);
    chk("t2_vrise", vrise - v0, 2);
    chk("t2_overrun", ov_cnt - o0, 0);
    chk("t2_data", data_o, 8'h69);

    // 3: false start, then glitch inside bit 0 of 0xA5
    v0 = vrise;
    line_i = 1'b0;
    for (int i = 0; i < CPB / 4; i++) begin
      if (i == 20) chk("t3_busy_fs", busy_o, 1);
      tick();
    end
    idle(300);
    chk("t3_busy_after", busy_o, 0);
    chk("t3_no_byte", vrise - v0, 0);
    send_frame(8'hA5, 1, CPB, CPB + MID + 1, -1, -1);
    idle(20);
    chk("t3_glitch_data", data_o, 8'hA5);
    read_pulse();

    // 4: bad stop then 20-bit break, then 0x3C
    v0 = vrise; f0 = fe_cnt;
    send_frame(8'hA5, 0, 21 * CPB, -1, -1, -1);
    idle(50);
    chk("t4_ferr_once", fe_cnt - f0, 1);
    chk("t4_valid", valid_o, 0);
    send_frame(8'h3C, 1, CPB, -1, -1, -1);
    idle(20);
    chk("t4_data", data_o, 8'h3C);
    chk("t4_vrise", vrise - v0, 1);
    read_pulse();

    // 5: overrun, then read coinciding with commit
    o0 = ov_cnt;
    send_frame(8'h11, 1, CPB, -1, -1, -1);
    send_frame(8'h22, 1, CPB, -1, -1, -1);
    idle(20);
    chk("t5_overrun", ov_cnt - o0, 1);
    chk("t5_data", data_o, 8'h22);
    chk("t5_valid", valid_o, 1);
    read_pulse();
    o0 = ov_cnt;
    send_frame(8'h33, 1, CPB, -1, -1, -1);
    send_frame(8'h44, 1, CPB, -1, 0, -1);
    idle(20);
    chk("t5_no_overrun", ov_cnt - o0, 0);
    chk("t5_data2", data_o, 8'h44);
    chk("t5_valid2", valid_o, 1);

    // 6: reset during bit 4 of 0xF0, then 0x0F
    v0 = vrise;
    send_frame(8'hF0, 1, CPB, -1, -1, 5 * CPB + 50);
    idle(50);
    chk("t6_no_byte", vrise - v0, 0);
    chk("t6_valid", valid_o, 0);
    send_frame(8'h0F, 1, CPB, -1, -1, -1);
    idle(20);
    chk("t6_data", data_o, 8'h0F);
    read_pulse();

    // random frames: short stops, glitches, occasional framing errors, random reads
    rand_rd = 1'b1;
    for (int n = 0; n < 8; n++) begin
      rb = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      sl = ok ? int'($urandom_range(125, CPB)) : int'($urandom_range(120, 3 * CPB));
      gk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(CPB, 9 * CPB - 1)) : -1;
      send_frame(rb, ok, sl, gk, -1, -1);
      idle(ok ? int'($urandom_range(0, 40)) : int'($urandom_range(4, 40)));
    end
    rand_rd = 1'b0;
    idle(200);
    chk("final_busy", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART 8N1 receiver, the receive-side counterpart of the simpleUARTtx serial transmitter.
- Runs on the main system clock and samples the asynchronous serial line directly, with no separate baud clock.
- Recovers each byte and holds it in a one-entry output register with a valid/read handshake for a downstream FSM or debug logic.
- Reports false starts (silently dropped), framing errors and overruns.

Parameters:
CLK_HZ, 24000000, system clock frequency in Hz.
BAUD, 115200, line bit rate.
CLKS_PER_BIT, CLK_HZ/BAUD (208), system clocks per bit, integer truncation; must be >= 8.
CNT_W, $clog2(CLKS_PER_BIT), width of the bit-timing counter.

Ports:
clk_i  in  1  system clock (24 MHz).
rstn_i  in  1  reset; asynchronous, active-low.
line_i  in  1  serial input, idle high, asynchronous to clk_i.
rd_i  in  1  consumer acknowledge; clears valid_o.
data_o  out  8  last good received byte, LSB first on the line.
valid_o  out  1  data_o holds an unread byte.
frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
overrun_o  out  1  one-cycle pulse: good byte arrived while valid_o=1 and rd_i=0.
busy_o  out  1  high in any state other than IDLE.

Behaviour:
Reset values:
- 2-FF synchronizer on line_i, both stages reset to 1.
- State IDLE, counter 0, shift register 0.
- data_o=0x00, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
- Reset asserted mid-frame aborts the frame immediately; a partial byte is never delivered.

Sampling:
- Majority vote of the synchronized line at counter values MID-1, MID, MID+1, where MID=CLKS_PER_BIT/2.
- The decision is taken at MID+1.

State machine:
- IDLE: on synchronized falling edge (prev=1, cur=0), clear counter and go to START.
- START: count. At the MID+1 decision:
  - vote=1: false start, back to IDLE, no outputs.
  - vote=0: clear counter, bit index=0, go to DATA.
  - The counter reference is now the start-bit center, so data bits are sampled one full CLKS_PER_BIT later.
- DATA: counter wraps at CLKS_PER_BIT-1. At each bit center (same MID-1..MID+1 window, offset from the wrap), shift the vote in LSB-first. After bit 7, go to STOP.
- STOP: at the stop-bit decision:
  - vote=1: commit. data_o<=shift register, valid_o<=1 on the next cycle; go to IDLE.
  - vote=0: frame_err_o pulses one cycle, byte discarded, data_o and valid_o unchanged; go to BRK_WAIT.
- BRK_WAIT: stay until the synchronized line is 1, then go to IDLE. A held-low line (break) produces exactly one frame_err_o pulse.

Handshake:
- valid_o stays 1 until a cycle with rd_i=1.
- rd_i with valid_o=0 is ignored.
- Commit while valid_o=1 and rd_i=0: overrun_o pulses, data_o is overwritten with the new byte, valid_o stays 1.
- Commit in the same cycle as rd_i=1: no overrun, data_o takes the new byte, valid_o stays 1.

Timing:
- Latency from the line falling edge to valid_o rising is 2 sync cycles plus about 9.5 bit times plus 2 cycles.
- The return to IDLE at the stop-bit center lets a following start bit, even with the stop bit shortened by up to 40%, be detected.

Test Plan:
1. 0x55 at 115200 baud, correct stop -> valid_o rises once about 9.5 bit times after the start edge; data_o=0x55; no error pulses.
2. Back-to-back 0x48 then 0x69 with no idle gap, rd_i pulsed after each valid_o -> two valid events, data 0x48 then 0x69, overrun_o never high.
3. Line low for CLKS_PER_BIT/4 (52 cycles), then high -> returns to IDLE, busy_o falls, valid_o stays 0. A 1-cycle low glitch inside a data bit is rejected by the vote, and 0xA5 is still received.
4. 0xA5 frame with stop bit low, line then held low 20 bit times -> exactly one frame_err_o pulse, valid_o stays 0. After the line returns high, 0x3C is received correctly.
5. 0x11 received and not read, then 0x22 received -> overrun_o pulses once, data_o=0x22, valid_o=1. Repeat with rd_i asserted in the commit cycle -> no overrun.
6. rstn_i low for 3 cycles during bit 4 of 0xF0 -> all outputs return to reset values immediately. The remaining bits do not produce a byte; the next full frame 0x0F is received correctly.
